countdown_timer: RTL
====================

# countdown_timer

BCD mm:ss countdown timer for the FPGA clock design. It counts down where the time-of-day counter chain counts up. The time is loaded with increment pulses from the setting keys, then decremented once per 1 Hz enable tick. When the count reaches 00:00 it raises an alarm for a programmable number of ticks. The digit outputs feed the same display mux as the clock digits.

## Interface
Parameters:
- ALARM_TICKS, default 10: number of `tick` pulses for which `alarm` stays high after expiry (valid range 1..255).

Ports:
- CP  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  1 Hz enable; one CP cycle wide.
- start_stop  input  1  single-cycle pulse (already debounced); toggles run/pause and acknowledges the alarm.
- clear  input  1  single-cycle synchronous clear.
- set_min  input  1  single-cycle pulse; minutes +1.
- set_sec  input  1  single-cycle pulse; seconds +1.
- min_tens  output  4  minutes tens digit, BCD 0..5.
- min_ones  output  4  minutes units digit, BCD 0..9.
- sec_tens  output  4  seconds tens digit, BCD 0..5.
- sec_ones  output  4  seconds units digit, BCD 0..9.
- running  output  1  high while in RUN.
- done  output  1  one-cycle pulse on the RUN→ALARM transition.
- alarm  output  1  high while in ALARM.

## Operation
- States: IDLE, RUN, PAUSE, ALARM. Encoding is free.
- Reset (reset=0) sets:
  - all digits to 0;
  - state to IDLE;
  - running, done and alarm to 0;
  - the alarm tick counter to 0.
- Priority within one cycle: clear > start_stop > set_min/set_sec > tick.
- clear in any state: digits become 00:00, state becomes IDLE, alarm counter is zeroed.
- Setting (IDLE and PAUSE only; ignored in RUN and ALARM):
  - set_sec increments seconds as BCD 00..59. 59 wraps to 00 with no carry into minutes.
  - set_min increments minutes as BCD 00..59. 59 wraps to 00.
  - set_min and set_sec in the same cycle both apply.
- IDLE:
  - start_stop with count ≠ 00:00 moves to RUN.
  - start_stop with count = 00:00 is ignored.
- RUN, on tick: the count decrements by one second with BCD borrow.
  - sec_ones 0→9 borrows from sec_tens.
  - sec_tens 0→5 borrows from min_ones.
  - min_ones 0→9 borrows from min_tens.
  - If the decremented value is 00:00: move to ALARM and pulse done in the same cycle the state enters ALARM.
- RUN, on start_stop: move to PAUSE. A tick in the same cycle is discarded, with no decrement.
- PAUSE:
  - start_stop with count ≠ 00:00 moves to RUN.
  - start_stop with count = 00:00 (reachable via set wrap) moves to IDLE.
  - Ticks are ignored.
- ALARM:
  - Digits hold 00:00 and alarm=1.
  - Each tick increments the alarm counter.
  - On the tick that makes the counter equal ALARM_TICKS: move to IDLE, alarm=0, counter cleared.
  - start_stop moves to IDLE immediately and clears the counter.
- The count never underflows: a decrement from 00:00 is unreachable because RUN is never entered at 00:00.
- Digits never take non-BCD values. Outputs must not exceed the stated ranges in any state.

## Timing
- All outputs are registered and change only on a CP rising edge, except on asynchronous reset assertion.
- tick, start_stop and set_* all act in the edge where they are sampled high. The effect is visible on outputs the following cycle (latency 1).
- done is high for exactly one cycle per expiry. alarm rises on the same edge as done.
- Alarm duration: alarm falls on the edge that samples the ALARM_TICKS-th tick after entry. The tick causing expiry does not count.
- Reset asserted mid-RUN or mid-ALARM: outputs go to reset values immediately (asynchronously). Operation resumes from IDLE on the first edge after release.
- Inputs wider than one cycle are not supported. Each high cycle counts as a separate event.

## Test plan
- Reset, then 2×set_min and 5×set_sec → display 02:05, running=0. Then start_stop → running=1 next cycle. Then 1 tick → 02:04.
- Borrow chain: load 10:00, RUN, 1 tick → 09:59. Load 01:00, 1 tick → 00:59.
- Expiry: load 00:02, RUN, 2 ticks → 00:00, done one cycle, alarm=1. Then ALARM_TICKS (10) ticks → alarm=0 and state IDLE.
- Simultaneous events:
  - In RUN at 00:30, start_stop and tick in the same cycle → PAUSE, display stays 00:30.
  - In PAUSE, set_sec ×30 → 00:00 (wrap). Then start_stop → IDLE, running stays 0.
- Start at 00:00 in IDLE: start_stop → no state change. set_sec on 00:59 → 00:00, minutes unchanged.
- Async reset mid-RUN at 03:17 → all digits 0 and running=0 without a clock edge. clear during ALARM → alarm=0 and 00:00 next cycle.

Source files
------------

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer: loaded with set pulses, decremented on each 1 Hz tick,
// and raises a timed alarm once the count expires at 00:00.
module countdown_timer #(
  parameter int ALARM_TICKS = 10
) (
  input  logic       CP,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       set_min,
  input  logic       set_sec,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam logic [7:0] LP_ALARM_TICKS = 8'(ALARM_TICKS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  state_t     r_state, w_stateNext;
  logic [3:0] r_minT, r_minO, r_secT, r_secO;
  logic [3:0] w_minTNext, w_minONext, w_secTNext, w_secONext;
  logic [3:0] w_decMinT, w_decMinO, w_decSecT, w_decSecO;
  logic [3:0] w_incMinT, w_incMinO, w_incSecT, w_incSecO;
  logic [7:0] r_alarmCnt, w_alarmCntNext;
  logic       r_done, w_doneNext;
  logic       w_isZero, w_decIsZero;

  assign w_isZero    = (r_minT == 4'd0) && (r_minO == 4'd0) &&
                       (r_secT == 4'd0) && (r_secO == 4'd0);
  assign w_decIsZero = (w_decMinT == 4'd0) && (w_decMinO == 4'd0) &&
                       (w_decSecT == 4'd0) && (w_decSecO == 4'd0);

  // One-second decrement with a BCD borrow chain; the minutes-tens guard keeps
  // the digit in range even though 00:00 is never decremented.
  always_comb begin
    w_decSecO = r_secO - 4'd1;
    w_decSecT = r_secT;
    w_decMinO = r_minO;
    w_decMinT = r_minT;
    if (r_secO == 4'd0) begin
      w_decSecO = 4'd9;
      if (r_secT == 4'd0) begin
        w_decSecT = 4'd5;
        if (r_minO == 4'd0) begin
          w_decMinO = 4'd9;
          if (r_minT != 4'd0) w_decMinT = r_minT - 4'd1;
        end else begin
          w_decMinO = r_minO - 4'd1;
        end
      end else begin
        w_decSecT = r_secT - 4'd1;
      end
    end
  end

  // Independent 00..59 wrap for each field; set_sec never carries into minutes.
  always_comb begin
    w_incSecO = r_secO + 4'd1;
    w_incSecT = r_secT;
    if (r_secO >= 4'd9) begin
      w_incSecO = 4'd0;
      w_incSecT = (r_secT >= 4'd5) ? 4'd0 : r_secT + 4'd1;
    end
    w_incMinO = r_minO + 4'd1;
    w_incMinT = r_minT;
    if (r_minO >= 4'd9) begin
      w_incMinO = 4'd0;
      w_incMinT = (r_minT >= 4'd5) ? 4'd0 : r_minT + 4'd1;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_minTNext     = r_minT;
    w_minONext     = r_minO;
    w_secTNext     = r_secT;
    w_secONext     = r_secO;
    w_alarmCntNext = r_alarmCnt;
    w_doneNext     = 1'b0;

    if (clear) begin
      w_stateNext    = IDLE;
      w_minTNext     = 4'd0;
      w_minONext     = 4'd0;
      w_secTNext     = 4'd0;
      w_secONext     = 4'd0;
      w_alarmCntNext = 8'd0;
    end else begin
      case (r_state)
        IDLE, PAUSE: begin
          if (start_stop) begin
            if (!w_isZero)             w_stateNext = RUN;
            else if (r_state == PAUSE) w_stateNext = IDLE;
          end else begin
            if (set_min) begin
              w_minTNext = w_incMinT;
              w_minONext = w_incMinO;
            end
            if (set_sec) begin
              w_secTNext = w_incSecT;
              w_secONext = w_incSecO;
            end
          end
        end
        RUN: begin
          if (start_stop) begin
            w_stateNext = PAUSE;
          end else if (tick) begin
            w_minTNext = w_decMinT;
            w_minONext = w_decMinO;
            w_secTNext = w_decSecT;
            w_secONext = w_decSecO;
            if (w_decIsZero) begin
              w_stateNext    = ALARM;
              w_doneNext     = 1'b1;
              w_alarmCntNext = 8'd0;
            end
          end
        end
        ALARM: begin
          if (start_stop) begin
            w_stateNext    = IDLE;
            w_alarmCntNext = 8'd0;
          end else if (tick) begin
            if (r_alarmCnt + 8'd1 >= LP_ALARM_TICKS) begin
              w_stateNext    = IDLE;
              w_alarmCntNext = 8'd0;
            end else begin
              w_alarmCntNext = r_alarmCnt + 8'd1;
            end
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_minT     <= 4'd0;
      r_minO     <= 4'd0;
      r_secT     <= 4'd0;
      r_secO     <= 4'd0;
      r_alarmCnt <= 8'd0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_minT     <= w_minTNext;
      r_minO     <= w_minONext;
      r_secT     <= w_secTNext;
      r_secO     <= w_secONext;
      r_alarmCnt <= w_alarmCntNext;
      r_done     <= w_doneNext;
    end
  end

  assign min_tens = r_minT;
  assign min_ones = r_minO;
  assign sec_tens = r_secT;
  assign sec_ones = r_secO;
  assign running  = (r_state == RUN);
  assign alarm    = (r_state == ALARM);
  assign done     = r_done;

endmodule
